// File: rtl/irs_stats_gen.sv
// Per-daughterboard IRS statistics: deadtime, occupancy and peak occupancy over 2^PERIOD_BITS clocks.
// Define IRS_STATS_AVG_EN to report period-averaged occupancy instead of the end-of-period snapshot.
module irs_stats_gen #(
  parameter int PERIOD_BITS = 24,
  parameter int OCC_BITS    = 9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dead_i,
  input  logic       alloc_i,
  input  logic       free_i,
  output logic [7:0] deadtime_o,
  output logic [7:0] occupancy_o,
  output logic [7:0] max_occupancy_o,
  output logic       update_o,
  output logic       err_o
);

  localparam logic [OCC_BITS-1:0] OCC_FULL = '1;

  logic [PERIOD_BITS-1:0] r_pcnt, r_dead, w_dead_nxt;
  logic [OCC_BITS-1:0]    r_occ, r_max, w_occ_nxt, w_max_nxt;
  logic [7:0]             r_deadtime, r_occupancy, r_max_occ, w_occ_rpt;
  logic                   r_update, r_err, w_err_set, w_tc;

  function automatic logic [7:0] sat8(input logic [OCC_BITS-1:0] v);
    return ((v >> 8) != '0) ? 8'hFF : v[7:0];
  endfunction

  assign w_tc = &r_pcnt;

  always_comb begin
    w_occ_nxt = r_occ;
    w_err_set = 1'b0;
    if (alloc_i && !free_i) begin
      if (r_occ == OCC_FULL) w_err_set = 1'b1;
      else                   w_occ_nxt = r_occ + 1'b1;
    end else if (free_i && !alloc_i) begin
      if (r_occ == '0) w_err_set = 1'b1;
      else             w_occ_nxt = r_occ - 1'b1;
    end
    w_dead_nxt = (dead_i && !(&r_dead)) ? r_dead + 1'b1 : r_dead;
    w_max_nxt  = (w_occ_nxt > r_max) ? w_occ_nxt : r_max;
  end

`ifdef IRS_STATS_AVG_EN
  localparam int AW = OCC_BITS + PERIOD_BITS;
  logic [AW-1:0] r_acc, w_acc_nxt, w_avg;

  // Accumulates the occupancy held during each cycle; the TC cycle's sum is the full period.
  assign w_acc_nxt = r_acc + AW'(r_occ);
  assign w_avg     = w_acc_nxt >> PERIOD_BITS;
  assign w_occ_rpt = (|w_avg[AW-1:8]) ? 8'hFF : w_avg[7:0];

  always_ff @(posedge clk_i) begin
    if (rst_i || w_tc) r_acc <= '0;
    else               r_acc <= w_acc_nxt;
  end
`else
  assign w_occ_rpt = sat8(w_occ_nxt);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt      <= '0;
      r_dead      <= '0;
      r_occ       <= '0;
      r_max       <= '0;
      r_deadtime  <= '0;
      r_occupancy <= '0;
      r_max_occ   <= '0;
      r_update    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pcnt   <= r_pcnt + 1'b1;
      r_occ    <= w_occ_nxt;
      r_update <= w_tc;
      if (w_err_set) r_err <= 1'b1;
      if (w_tc) begin
        // Publish figures that include the TC cycle, then start the next period fresh.
        r_dead      <= '0;
        r_max       <= w_occ_nxt;
        r_deadtime  <= w_dead_nxt[PERIOD_BITS-1 -: 8];
        r_occupancy <= w_occ_rpt;
        r_max_occ   <= sat8(w_max_nxt);
      end else begin
        r_dead <= w_dead_nxt;
        r_max  <= w_max_nxt;
      end
    end
  end

  assign deadtime_o      = r_deadtime;
  assign occupancy_o     = r_occupancy;
  assign max_occupancy_o = r_max_occ;
  assign update_o        = r_update;
  assign err_o           = r_err;

endmodule

// File: tb/tb_irs_stats_gen.sv
// Directed plus randomized bench for irs_stats_gen with an arithmetic per-period reference model.
module tb_irs_stats_gen;
  localparam int PB = 8;
  localparam int PLEN = 1 << PB;
  localparam int OCC_MAX = 511;

  logic       clk_i = 1'b0;
  logic       rst_i, dead_i, alloc_i, free_i;
  logic [7:0] deadtime_o, occupancy_o, max_occupancy_o;
  logic       update_o, err_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_pos, m_dead, m_occ, m_max, m_err;
  longint m_acc;
  int e_dt, e_occ, e_max, e_upd;

  irs_stats_gen #(.PERIOD_BITS(PB), .OCC_BITS(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dead_i(dead_i), .alloc_i(alloc_i), .free_i(free_i),
    .deadtime_o(deadtime_o), .occupancy_o(occupancy_o), .max_occupancy_o(max_occupancy_o),
    .update_o(update_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".update"}, {31'd0, update_o}, e_upd);
    chk({tag, ".err"}, {31'd0, err_o}, m_err);
    chk({tag, ".deadtime"}, {24'd0, deadtime_o}, e_dt);
    chk({tag, ".occ"}, {24'd0, occupancy_o}, e_occ);
    chk({tag, ".max"}, {24'd0, max_occupancy_o}, e_max);
  endtask

  function automatic int min255(input longint v);
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_dead = 0; m_occ = 0; m_max = 0; m_err = 0; m_acc = 0;
    e_dt = 0; e_occ = 0; e_max = 0; e_upd = 0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; dead_i = 1'b0; alloc_i = 1'b0; free_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
    model_reset();
    chk_all("reset");
    rst_i = 1'b0;
  endtask

  // One clock of stimulus; the model advances by the rules for that cycle.
  task automatic cyc(input logic d, input logic a, input logic f);
    dead_i = d; alloc_i = a; free_i = f;
    @(posedge clk_i);
    #1;
    if (d) m_dead++;
    m_acc += m_occ;
    if (a && !f) begin
      if (m_occ == OCC_MAX) m_err = 1; else m_occ++;
    end else if (f && !a) begin
      if (m_occ == 0) m_err = 1; else m_occ--;
    end
    if (m_occ > m_max) m_max = m_occ;
    if (m_pos == PLEN - 1) begin
      e_dt  = min255(m_dead);
`ifdef IRS_STATS_AVG_EN
      e_occ = min255(m_acc / PLEN);
`else
      e_occ = min255(m_occ);
`endif
      e_max = min255(m_max);
      e_upd = 1;
      m_dead = 0; m_max = m_occ; m_acc = 0;
    end else begin
      e_upd = 0;
    end
    m_pos = (m_pos + 1) % PLEN;
    chk_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; dead_i = 1'b0; alloc_i = 1'b0; free_i = 1'b0;
    do_reset(3);

    // half-period deadtime
    for (int i = 0; i < PLEN; i++) cyc(i < PLEN / 2, 1'b0, 1'b0);
    chk("dt_half", {24'd0, deadtime_o}, 128);
    chk("dt_half_upd", {31'd0, update_o}, 1);

    // fully dead period saturates rather than wrapping
    for (int i = 0; i < PLEN; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("dt_full", {24'd0, deadtime_o}, 255);

    // 10 allocs then 4 frees
    for (int i = 0; i < PLEN; i++) cyc(1'b0, (i < 20) && (i % 2 == 0), (i >= 30) && (i < 34));
    chk("occ_6", {24'd0, occupancy_o}, 6);
    chk("max_10", {24'd0, max_occupancy_o}, 10);
    idle(PLEN);
    chk("occ_6_hold", {24'd0, occupancy_o}, 6);
    chk("max_6", {24'd0, max_occupancy_o}, 6);

    // down to 3, then simultaneous alloc/free
    for (int i = 0; i < PLEN; i++) cyc(1'b0, i == 10, (i < 3) || (i == 10));
    chk("both_occ", {24'd0, occupancy_o}, 3);
    chk("both_err", {31'd0, err_o}, 0);

    // underflow is sticky across periods
    do_reset(2);
    cyc(1'b0, 1'b0, 1'b1);
    idle(2 * PLEN - 1);
    chk("underflow_err", {31'd0, err_o}, 1);
    chk("underflow_occ", {24'd0, occupancy_o}, 0);

    // 300 allocs saturate the reported figures
    do_reset(2);
    for (int i = 0; i < 2 * PLEN; i++) cyc(1'b0, i < 300, 1'b0);
    chk("sat_occ", {24'd0, occupancy_o}, 255);
    chk("sat_max", {24'd0, max_occupancy_o}, 255);

    // mid-period reset discards partial results
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0);
    do_reset(2);
    idle(PLEN - 1);
    chk("post_rst_noupd", {31'd0, update_o}, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_upd", {31'd0, update_o}, 1);

    // randomized periods with varying densities
    for (int p = 0; p < 6; p++) begin
      int dd, da, df;
      dd = $urandom_range(0, 4); da = $urandom_range(1, 4); df = $urandom_range(1, 5);
      for (int i = 0; i < PLEN; i++)
        cyc($urandom_range(0, 4) < dd, $urandom_range(0, 5) < da, $urandom_range(0, 5) < df);
    end

    // drive to full scale: the alloc at 511 flags an error
    for (int i = 0; i < 3 * PLEN; i++) cyc($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    chk("full_err", {31'd0, err_o}, 1);
    idle(PLEN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irs_stats_gen.md
Name: irs_stats_gen

Overview:
- Per-daughterboard statistics producer. Turns raw IRS readout events into the three 8-bit figures consumed by the Wishbone statistics register block: deadtime, occupancy and max occupancy.
- One instance per daughter, sitting in the IRS readout clock domain next to the block manager.
- Measures over fixed periods of 2^PERIOD_BITS clocks. Publishes latched results once per period with a one-cycle update strobe.

Parameters:
- PERIOD_BITS, 24, log2 of the measurement period in clocks; legal range 8..31.
- OCC_BITS, 9, width of the live block-occupancy counter (max 2^OCC_BITS-1 blocks).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- dead_i  input  1  high on every cycle the digitizer cannot accept a trigger
- alloc_i  input  1  one-cycle pulse, one IRS block allocated
- free_i  input  1  one-cycle pulse, one IRS block released
- deadtime_o  output  8  deadtime fraction of the last period, units of 1/256
- occupancy_o  output  8  occupancy at the end of the last period (see Optional Feature)
- max_occupancy_o  output  8  peak occupancy during the last period
- update_o  output  1  one-cycle pulse when the outputs above change
- err_o  output  1  sticky: a free with occupancy 0, or an alloc at full scale

Behaviour:
- Reset (rst_i high at a clock edge):
  - period counter, dead counter, live occupancy, running max, all outputs and err_o go to 0;
  - the period restarts on the first cycle after rst_i deasserts;
  - reset mid-period discards partial results, with no update_o.
- Period counter: PERIOD_BITS wide, free-running, increments every clock. Terminal count (TC) is all ones.
- Dead counter: PERIOD_BITS wide.
  - Increments on each cycle dead_i=1, saturating at all ones.
  - The TC cycle's dead_i is included.
  - Cleared to 0 for the first cycle of the next period.
- Live occupancy: OCC_BITS up/down counter.
  - alloc_i only: +1, saturating at 2^OCC_BITS-1; alloc at full scale sets err_o.
  - free_i only: -1, floor 0; free at 0 sets err_o.
  - Both asserted together: no change, no error.
  - Live occupancy is not cleared at period boundaries.
- Running max:
  - Each cycle, max <= max(max, next live occupancy).
  - At TC the running max reloads with the next live occupancy value.
- Output latch: on the edge ending the TC cycle, all outputs update simultaneously and update_o is 1 for exactly that following cycle.
  - deadtime_o = dead counter bits [PERIOD_BITS-1:PERIOD_BITS-8], using the value including the TC cycle.
  - occupancy_o = live occupancy after TC-cycle events, saturated to 255 if above 255.
  - max_occupancy_o = running max including TC-cycle events, saturated to 255.
  - Outputs hold until the next TC.
- Latency: an event on the TC cycle appears in the outputs 1 clock later. An event on TC+1 first appears one full period later.
- err_o is sticky; only rst_i clears it.
- update_o is never asserted twice within a period.

Optional Feature:
- Macro IRS_STATS_AVG_EN.
- Defined:
  - an accumulator of width OCC_BITS+PERIOD_BITS adds the live occupancy every cycle, TC cycle included;
  - at TC, occupancy_o = accumulator >> PERIOD_BITS, saturated to 255;
  - the accumulator is cleared for the next period and on reset.
- Undefined: no accumulator is built and occupancy_o is the end-of-period snapshot described above.
- Every other output behaves identically either way.

Test Plan (PERIOD_BITS=8, OCC_BITS=9, macro undefined unless stated):
- Reset, then dead_i=1 on cycles 0..127 of the period -> at period end update_o pulses once; deadtime_o=128, occupancy_o=0, max_occupancy_o=0, err_o=0.
- dead_i=1 for all 256 cycles -> deadtime_o=255 (saturation), with no wrap to 0.
- 10 alloc_i pulses, then 4 free_i pulses in one period -> occupancy_o=6, max_occupancy_o=10. Next period with no events -> occupancy_o=6, max_occupancy_o=6.
- alloc_i and free_i together at occupancy 3 -> remains 3, err_o=0. free_i at occupancy 0 -> stays 0, err_o=1 and held through later periods until rst_i.
- 300 allocs -> occupancy_o=255, max_occupancy_o=255. rst_i asserted mid-period -> all outputs 0, no update_o until 256 cycles after release.
- IRS_STATS_AVG_EN defined: occupancy 0 for 128 cycles, then 100 for 128 cycles -> occupancy_o=50, max_occupancy_o=100.
